// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: registered round-robin arbiter sharing the single-port
// program/data RAM between the CPU datapath and the program loader/debug port.
// One access is placed on the RAM bus per grant cycle. Read data returns one
// cycle later and is routed to whichever requester owned that grant.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  // CPU datapath port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  // loader/debug port
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_excl,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  // RAM pins
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GNT_CPU = 2'd1,
    S_GNT_LD  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_ld;      // 1: loader owned the most recent grant
  logic              r_cpu_rvalid;   // read pending, returning to the CPU
  logic              r_ld_rvalid;    // read pending, returning to the loader
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              w_cpu_elig;
  logic              w_ld_elig;

  // Exclusive mode withholds the CPU from every arbitration decision.
  assign w_cpu_elig = cpu_req & ~ld_excl;
  assign w_ld_elig  = ld_req;

  // Next-state selection: round-robin from IDLE, hand-over from a grant.
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_cpu_elig && w_ld_elig) begin
          w_state_nxt = r_last_ld ? S_GNT_CPU : S_GNT_LD;
        end else if (w_cpu_elig) begin
          w_state_nxt = S_GNT_CPU;
        end else if (w_ld_elig) begin
          w_state_nxt = S_GNT_LD;
        end
      end
      S_GNT_CPU: if (w_ld_elig)  w_state_nxt = S_GNT_LD;
      S_GNT_LD:  if (w_cpu_elig) w_state_nxt = S_GNT_CPU;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // RAM bus launch, ownership history and read-return routing.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_last_ld    <= 1'b1;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= '0;
      r_cpu_rvalid <= 1'b0;
      r_ld_rvalid  <= 1'b0;
    end else begin
      case (w_state_nxt)
        S_GNT_CPU: begin
          r_last_ld   <= 1'b0;
          r_mem_addr  <= cpu_addr;
          r_mem_we    <= cpu_we;
          r_mem_wdata <= cpu_wdata;
        end
        S_GNT_LD: begin
          r_last_ld   <= 1'b1;
          r_mem_addr  <= ld_addr;
          r_mem_we    <= ld_we;
          r_mem_wdata <= ld_wdata;
        end
        default: r_mem_we <= 1'b0;
      endcase
      r_cpu_rvalid <= (r_state == S_GNT_CPU) && !r_mem_we;
      r_ld_rvalid  <= (r_state == S_GNT_LD)  && !r_mem_we;
    end
  end

  assign cpu_gnt    = (r_state == S_GNT_CPU);
  assign ld_gnt     = (r_state == S_GNT_LD);
  assign cpu_rvalid = r_cpu_rvalid;
  assign ld_rvalid  = r_ld_rvalid;
  assign cpu_rdata  = mem_rdata;
  assign ld_rdata   = mem_rdata;
  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign mem_addr   = r_mem_addr;
  assign mem_we     = r_mem_we;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// all checked against a transaction-level model of grants and RAM contents.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;

  logic              CLOCK_50 = 1'b0;
  logic              reset = 1'b0;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_gnt, cpu_rvalid, cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ld_req = 1'b0, ld_we = 1'b0, ld_excl = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_wdata = '0;
  logic              ld_gnt, ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_excl(ld_excl), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Synchronous RAM; reset loads a known pattern.
  logic [DATA_W-1:0] ram [32];
  always @(posedge CLOCK_50) begin
    mem_rdata <= ram[mem_addr];
    if (!reset) begin
      for (int i = 0; i < 32; i++) ram[i] <= 8'(i * 37 + 5);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus this cycle, who was served last,
  // what the bus should carry, and what the RAM should hold.
  int                m_gnt;   // 0 none, 1 cpu, 2 loader
  int                m_last;  // 1 cpu, 2 loader
  logic              exp_we, exp_cpu_rv, exp_ld_rv;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wdata, exp_rdata;
  logic [DATA_W-1:0] shadow [32];

  // Output snapshot taken at the sampling point of the last cycle.
  logic              s_cpu_gnt, s_ld_gnt, s_cpu_rv, s_ld_rv, s_mem_we, s_stall;
  logic [ADDR_W-1:0] s_mem_addr;
  logic [DATA_W-1:0] s_cpu_rdata, s_ld_rdata;

  task automatic model_reset();
    m_gnt = 0; m_last = 2;
    exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
    exp_cpu_rv = 1'b0; exp_ld_rv = 1'b0;
    for (int i = 0; i < 32; i++) shadow[i] = 8'(i * 37 + 5);
  endtask

  // One clock cycle: compare at the falling edge, advance the model, then
  // return just after the next rising edge ready for new stimulus.
  task automatic cyc();
    int  nxt;
    bit  ce, le;
    @(negedge CLOCK_50);
    s_cpu_gnt = cpu_gnt; s_ld_gnt = ld_gnt; s_cpu_rv = cpu_rvalid; s_ld_rv = ld_rvalid;
    s_mem_we = mem_we; s_mem_addr = mem_addr; s_stall = cpu_stall;
    s_cpu_rdata = cpu_rdata; s_ld_rdata = ld_rdata;
    check_val("cpu_gnt", 32'(cpu_gnt), 32'(m_gnt == 1));
    check_val("ld_gnt", 32'(ld_gnt), 32'(m_gnt == 2));
    check_val("mem_we", 32'(mem_we), 32'(exp_we));
    check_val("mem_addr", 32'(mem_addr), 32'(exp_addr));
    check_val("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
    check_val("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_cpu_rv));
    check_val("ld_rvalid", 32'(ld_rvalid), 32'(exp_ld_rv));
    check_val("cpu_stall", 32'(cpu_stall), 32'(cpu_req && m_gnt != 1));
    if (exp_cpu_rv) check_val("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata));
    if (exp_ld_rv)  check_val("ld_rdata", 32'(ld_rdata), 32'(exp_rdata));
    // access on the bus now completes: reads return next cycle, writes land
    exp_cpu_rv = (m_gnt == 1) && !exp_we;
    exp_ld_rv  = (m_gnt == 2) && !exp_we;
    exp_rdata  = shadow[exp_addr];
    if (m_gnt != 0 && exp_we) shadow[exp_addr] = exp_wdata;
    // next owner: eligible requesters other than the current owner, least recent first
    ce = cpu_req && !ld_excl && m_gnt != 1;
    le = ld_req && m_gnt != 2;
    if (ce && le)  nxt = (m_last == 1) ? 2 : 1;
    else if (ce)   nxt = 1;
    else if (le)   nxt = 2;
    else           nxt = 0;
    if (nxt == 1) begin
      exp_we = cpu_we; exp_addr = cpu_addr; exp_wdata = cpu_wdata;
    end else if (nxt == 2) begin
      exp_we = ld_we; exp_addr = ld_addr; exp_wdata = ld_wdata;
    end else begin
      exp_we = 1'b0;
    end
    if (nxt != 0) m_last = nxt;
    m_gnt = nxt;
    @(posedge CLOCK_50);
    #1;
  endtask

  // Requesters that hold until granted, then re-request or go quiet.
  task automatic drive_auto(input int pct_cpu, input int pct_ld, input int pct_excl);
    if (!cpu_req || s_cpu_gnt) begin
      cpu_req = ($urandom_range(0, 99) < pct_cpu);
      cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = 5'($urandom); cpu_wdata = 8'($urandom);
    end
    if (!ld_req || s_ld_gnt) begin
      ld_req = ($urandom_range(0, 99) < pct_ld);
      ld_we = 1'($urandom_range(0, 1));
      ld_addr = 5'($urandom); ld_wdata = 8'($urandom);
    end
    ld_excl = ($urandom_range(0, 99) < pct_excl);
  endtask

  task automatic quiet();
    cpu_req = 1'b0; ld_req = 1'b0; ld_excl = 1'b0;
  endtask

  initial begin
    int n_cpu, n_ld, n_both, first;
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    #1;
    check_val("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_val("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    @(negedge CLOCK_50); reset = 1'b1;
    @(posedge CLOCK_50); #1;

    // 1: single CPU read after the loader plants 0xA5 at 0x03
    ld_req = 1; ld_we = 1; ld_addr = 5'h03; ld_wdata = 8'hA5;
    cyc(); cyc(); ld_req = 0; cyc();
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'h03;
    cyc(); check_val("t1_stall_c0", 32'(s_stall), 32'd1);
    cyc(); check_val("t1_gnt", 32'(s_cpu_gnt), 32'd1);
    check_val("t1_addr", 32'(s_mem_addr), 32'h03);
    check_val("t1_we", 32'(s_mem_we), 32'd0);
    check_val("t1_stall_c1", 32'(s_stall), 32'd0);
    cpu_req = 0;
    cyc(); check_val("t1_rvalid", 32'(s_cpu_rv), 32'd1);
    check_val("t1_rdata", 32'(s_cpu_rdata), 32'hA5);

    // 2: simultaneous requests right after reset, CPU wins first
    @(negedge CLOCK_50); reset = 1'b0; model_reset();
    @(posedge CLOCK_50); @(negedge CLOCK_50); reset = 1'b1;
    @(posedge CLOCK_50); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'h01;
    ld_req = 1; ld_we = 0; ld_addr = 5'h02;
    cyc();
    cyc(); check_val("t2_cpu_first", 32'(s_cpu_gnt), 32'd1);
    check_val("t2_ld_wait", 32'(s_ld_gnt), 32'd0);
    cpu_req = 0;
    cyc(); check_val("t2_ld_gnt", 32'(s_ld_gnt), 32'd1);
    check_val("t2_cpu_rv", 32'(s_cpu_rv), 32'd1);
    check_val("t2_cpu_rdata", 32'(s_cpu_rdata), 32'h2A);
    ld_req = 0;
    cyc(); check_val("t2_ld_rv", 32'(s_ld_rv), 32'd1);
    check_val("t2_ld_rdata", 32'(s_ld_rdata), 32'h4F);

    // 3: loader write then CPU read of the same word
    ld_req = 1; ld_we = 1; ld_addr = 5'h10; ld_wdata = 8'h3C;
    cyc(); check_val("t3_we_c0", 32'(s_mem_we), 32'd0);
    cyc(); check_val("t3_we_gnt", 32'(s_mem_we), 32'd1);
    ld_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 5'h10;
    cyc(); check_val("t3_we_after", 32'(s_mem_we), 32'd0);
    cyc(); check_val("t3_cpu_gnt", 32'(s_cpu_gnt), 32'd1);
    cpu_req = 0;
    cyc(); check_val("t3_rdata", 32'(s_cpu_rdata), 32'h3C);

    // 4: exclusive mode locks the CPU out, release lets it in quickly
    n_cpu = 0; n_ld = 0;
    for (int k = 0; k < 12; k++) begin
      drive_auto(100, 100, 100); cyc();
      if (s_cpu_gnt) n_cpu++;
      if (s_ld_gnt) n_ld++;
      if (k > 0 && !s_stall) check_val("t4_stall", 32'(s_stall), 32'd1);
    end
    check_val("t4_no_cpu", 32'(n_cpu), 32'd0);
    check_val("t4_ld_some", 32'(n_ld > 0), 32'd1);
    first = 0;
    for (int k = 1; k <= 4; k++) begin
      drive_auto(100, 100, 0); cyc();
      if (s_cpu_gnt && first == 0) first = k;
    end
    check_val("t4_release_lat", 32'(first >= 1 && first <= 2), 32'd1);

    // 5: continuous contention alternates strictly
    quiet(); cyc(); cyc(); cyc();
    n_cpu = 0; n_ld = 0; n_both = 0;
    for (int k = 0; k < 11; k++) begin
      drive_auto(100, 100, 0); cyc();
      if (k > 0) begin
        if (s_cpu_gnt) n_cpu++;
        if (s_ld_gnt) n_ld++;
        if (s_cpu_gnt && s_ld_gnt) n_both++;
      end
    end
    check_val("t5_cpu_cnt", 32'(n_cpu), 32'd5);
    check_val("t5_ld_cnt", 32'(n_ld), 32'd5);
    check_val("t5_overlap", 32'(n_both), 32'd0);

    // 6: reset in the middle of a CPU read grant
    quiet(); cyc(); cyc(); cyc();
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'h07;
    cyc();
    #2 reset = 1'b0;
    #1;
    check_val("t6_gnt_rst", 32'(cpu_gnt), 32'd0);
    check_val("t6_addr_rst", 32'(mem_addr), 32'd0);
    check_val("t6_we_rst", 32'(mem_we), 32'd0);
    check_val("t6_rv_rst", 32'(cpu_rvalid), 32'd0);
    cpu_req = 0; model_reset();
    @(posedge CLOCK_50); @(negedge CLOCK_50); reset = 1'b1;
    @(posedge CLOCK_50); #1;
    cyc(); check_val("t6_no_rv", 32'(s_cpu_rv), 32'd0);
    cyc();
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'h07;
    cyc();
    cyc(); check_val("t6_regrant", 32'(s_cpu_gnt), 32'd1);
    cpu_req = 0;
    cyc(); check_val("t6_rdata", 32'(s_cpu_rdata), 32'(8'(7 * 37 + 5)));

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      drive_auto(60, 50, 20); cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port program/data RAM between two requesters:
  - the CPU datapath, which covers instruction fetch, load/add/sub operand reads and store writes;
  - an external program loader/debug port.
- Sits between the control-unit/datapath and the RAM, and drives all RAM address, write-enable and write-data pins.
- Registered round-robin arbitration, one access per grant cycle.
- A loader-exclusive mode lets a program be written while the CPU is held off.

Parameters:
- ADDR_W, 5, RAM address width.
- DATA_W, 8, RAM data width.

Ports:
- CLOCK_50  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_gnt is seen.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  one-cycle pulse: CPU access is on the RAM bus this cycle.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata is valid.
- cpu_rdata  out  DATA_W  read data (mem_rdata, unregistered).
- cpu_stall  out  1  cpu_req & ~cpu_gnt (combinational).
- ld_req  in  1  loader request; same rules as cpu_req.
- ld_we  in  1  loader write enable.
- ld_addr  in  ADDR_W  loader address.
- ld_wdata  in  DATA_W  loader write data.
- ld_excl  in  1  loader-exclusive mode; blocks CPU grants.
- ld_gnt  out  1  loader grant pulse.
- ld_rvalid  out  1  loader read-data valid pulse.
- ld_rdata  out  DATA_W  loader read data (mem_rdata).
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_wdata  out  DATA_W  RAM write data (registered).
- mem_rdata  in  DATA_W  RAM read data; synchronous RAM, valid one cycle after the address.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE, last_owner = LD.
  - All gnt/rvalid outputs, mem_we, mem_addr and mem_wdata are 0.
  - Any read in flight is dropped: no rvalid follows reset release.
- States: IDLE, GNT_CPU, GNT_LD. gnt_X = 1 exactly while in GNT_X.
- Eligibility:
  - cpu_eligible = cpu_req & ~ld_excl.
  - ld_eligible = ld_req.
- Transitions from IDLE:
  - Both eligible: go to the one that is not last_owner.
  - One eligible: go to it.
  - None eligible: stay in IDLE.
- Transitions from GNT_X:
  - The granted requester's own req is ignored this cycle.
  - Other requester eligible: go to GNT_other (back-to-back alternation).
  - Otherwise: go to IDLE.
- Entering GNT_X:
  - last_owner <= X.
  - mem_addr/mem_we/mem_wdata <= X's request inputs sampled on the same edge, so the RAM sees the access during the grant cycle.
- Leaving GNT for IDLE: mem_we <= 0; mem_addr and mem_wdata hold their values.
- Timing, requester asserting req in cycle N with the arbiter free:
  - gnt in cycle N+1.
  - For a read, X_rvalid = 1 in cycle N+2, with X_rdata equal to RAM[addr].
  - A write completes at the end of cycle N+1; no rvalid is issued for writes.
- Requester obligations:
  - Hold req/we/addr/wdata stable from assertion until the gnt cycle.
  - Deassert or present a new request in the cycle after gnt.
- Throughput:
  - Single requester: 1 access per 2 cycles.
  - Both requesting: 1 access per cycle, strictly alternating.
- ld_excl:
  - Sampled combinationally at each arbitration decision.
  - Asserting it never aborts a GNT_CPU already in progress.
  - While it is high, the CPU is never granted and cpu_stall follows cpu_req.
- Read return: a registered rd_owner/rd_pending pair routes rvalid to the requester granted in the previous cycle. Only one rvalid is active per cycle.
- Read-during-write: not possible, since each grant cycle carries exactly one access.

Test Plan:
1. RAM[0x03]=0xA5; cpu_req=1, cpu_we=0, cpu_addr=0x03 at cycle 0 -> cpu_gnt in cycle 1 with mem_addr=0x03, mem_we=0; cpu_rvalid in cycle 2 with cpu_rdata=0xA5; cpu_stall=1 in cycle 0 only.
2. After reset, cpu_req and ld_req both raised in the same cycle (reads of 0x01 and 0x02) -> cpu_gnt in cycle 1, ld_gnt in cycle 2; cpu_rvalid in cycle 2, ld_rvalid in cycle 3, each with the correct data.
3. Loader writes 0x3C to 0x10, then CPU reads 0x10 -> mem_we=1 only in the ld_gnt cycle; cpu_rdata=0x3C.
4. ld_excl=1 with both requesting continuously -> only ld_gnt pulses and cpu_stall stays 1; ld_excl dropped -> cpu_gnt within 2 cycles.
5. Both requesting continuously for 10 cycles -> strict alternation CPU, LD, CPU, ...; exactly 5 grants each; never two gnts in the same cycle.
6. reset pulled low during GNT_CPU of a read -> all outputs 0 immediately; no cpu_rvalid after release; the next cpu_req is served normally with 1-cycle grant latency.
